alarma_ctrl: RTL and testbench

Alarm sequencer of the RTC: compares current BCD time against programmed alarm time on each one-second tick, and drives `activar_alarma` to the VGA ring-icon renderer and a buzzer output. Handles stop, snooze and auto-timeout. Sits between the RTC time registers/button debouncers and the VGA text/icon overlay.

---
 rtl/alarma_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_alarma_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alarma_ctrl.sv
// -----------------------------------------------------------------------------
// alarma_ctrl - RTC alarm sequencer
//
// On every one-second tick the current BCD time is compared against the
// programmed alarm hour/minute (at second 00). A match starts the ringing
// phase, which drives the VGA ring icon (activar_alarma) and a 0.5 Hz buzzer
// square wave. Ringing ends on stop, alarm disarm, or after RING_SECONDS
// ticks. With snooze enabled, a snooze press parks the sequencer for
// SNOOZE_SECONDS ticks and then rings again.
//
// Build option:
//   ALARMA_SNOOZE_EN  defined     -> SNOOZE state and btn_snooze active
//                     not defined -> btn_snooze ignored, SNOOZE unreachable
//
// Parameters:
//   RING_SECONDS    ticks of ringing before automatic stop (1..511)
//   SNOOZE_SECONDS  snooze length in ticks (1..511)
//
// Ports:
//   clk             system clock
//   reset           asynchronous reset, active low
//   tick_1s         one-cycle pulse per second
//   hora_bcd        current hours, BCD
//   min_bcd         current minutes, BCD
//   seg_bcd         current seconds, BCD
//   alarm_hora_bcd  programmed alarm hours, BCD
//   alarm_min_bcd   programmed alarm minutes, BCD
//   alarm_en        alarm armed (level)
//   btn_stop        debounced stop button level, active high
//   btn_snooze      debounced snooze button level, active high
//   activar_alarma  high while ringing (registered)
//   buzzer          toggles on each tick while ringing (registered)
//   estado          state encoding: 0 IDLE, 1 RINGING, 2 SNOOZE
// -----------------------------------------------------------------------------
module alarma_ctrl #(
    parameter int unsigned RING_SECONDS   = 60,
    parameter int unsigned SNOOZE_SECONDS = 300
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1s,
    input  logic [7:0] hora_bcd,
    input  logic [7:0] min_bcd,
    input  logic [7:0] seg_bcd,
    input  logic [7:0] alarm_hora_bcd,
    input  logic [7:0] alarm_min_bcd,
    input  logic       alarm_en,
    input  logic       btn_stop,
    input  logic       btn_snooze,
    output logic       activar_alarma,
    output logic       buzzer,
    output logic [1:0] estado
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZE  = 2'd2,
        ST_ILLEGAL = 2'd3
    } state_t;

    localparam logic [8:0] RING_CNT = 9'(RING_SECONDS);

    state_t     r_state;
    logic [8:0] r_cnt;
    logic       r_stop_q;
    logic       r_stop_p;
    logic       w_match;
    logic       w_cnt_last;

    // Alarm fires only at second 00 of the matching minute, so arming
    // mid-minute waits for the next occurrence.
    assign w_match = tick_1s && alarm_en &&
                     (hora_bcd == alarm_hora_bcd) &&
                     (min_bcd  == alarm_min_bcd)  &&
                     (seg_bcd  == 8'h00);

    assign w_cnt_last = (r_cnt == 9'd1);

    // The state register itself is the debug encoding, so estado is registered.
    assign estado = r_state;

    // Button edge detectors. The delay flops reset to 1 so a button held
    // through reset release does not look like a fresh press. The pulse is
    // registered, giving press-to-state latency of two edges.
    // NOTE: all sequential state uses non-blocking (<=) assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stop_q <= 1'b1;
            r_stop_p <= 1'b0;
        end else begin
            r_stop_q <= btn_stop;
            r_stop_p <= btn_stop & ~r_stop_q;
        end
    end

`ifdef ALARMA_SNOOZE_EN
    localparam logic [8:0] SNOOZE_CNT = 9'(SNOOZE_SECONDS);

    logic r_snooze_q;
    logic r_snooze_p;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_snooze_q <= 1'b1;
            r_snooze_p <= 1'b0;
        end else begin
            r_snooze_q <= btn_snooze;
            r_snooze_p <= btn_snooze & ~r_snooze_q;
        end
    end
`else
    // Snooze is compiled out; these inputs are intentionally unconnected.
    logic w_unused_snooze;
    assign w_unused_snooze = &{1'b0, btn_snooze, SNOOZE_SECONDS[0]};
`endif

    // Sequencer with registered outputs. Outputs default to 0 and are only
    // raised on paths that end in (or stay in) RINGING, so every exit from
    // RINGING forces the buzzer low on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state        <= ST_IDLE;
            r_cnt          <= 9'd0;
            activar_alarma <= 1'b0;
            buzzer         <= 1'b0;
        end else begin
            activar_alarma <= 1'b0;
            buzzer         <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_match) begin
                        r_state        <= ST_RINGING;
                        r_cnt          <= RING_CNT;
                        activar_alarma <= 1'b1;
                    end
                end

                ST_RINGING: begin
                    if (!alarm_en || r_stop_p) begin
                        r_state <= ST_IDLE;
`ifdef ALARMA_SNOOZE_EN
                    end else if (r_snooze_p) begin
                        r_state <= ST_SNOOZE;
                        r_cnt   <= SNOOZE_CNT;
`endif
                    end else if (tick_1s && w_cnt_last) begin
                        r_state <= ST_IDLE;
                    end else begin
                        activar_alarma <= 1'b1;
                        buzzer         <= buzzer ^ tick_1s;
                        if (tick_1s) begin
                            r_cnt <= r_cnt - 9'd1;
                        end
                    end
                end

`ifdef ALARMA_SNOOZE_EN
                ST_SNOOZE: begin
                    if (!alarm_en || r_stop_p) begin
                        r_state <= ST_IDLE;
                    end else if (tick_1s && w_cnt_last) begin
                        r_state        <= ST_RINGING;
                        r_cnt          <= RING_CNT;
                        activar_alarma <= 1'b1;
                    end else if (tick_1s) begin
                        r_cnt <= r_cnt - 9'd1;
                    end
                end
`endif

                // Unused encodings (and SNOOZE when compiled out) recover to IDLE.
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alarma_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alarma_ctrl - directed self-checking bench for alarma_ctrl
// RING_SECONDS=5, SNOOZE_SECONDS=3. Inputs are driven 1 ns after the rising
// edge and outputs are sampled at the same point, away from the active edge.
// -----------------------------------------------------------------------------
module tb_alarma_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick_1s;
    logic [7:0] hora_bcd, min_bcd, seg_bcd;
    logic [7:0] alarm_hora_bcd, alarm_min_bcd;
    logic       alarm_en, btn_stop, btn_snooze;
    logic       activar_alarma, buzzer;
    logic [1:0] estado;

    int n_cmp = 0;
    int n_err = 0;

    alarma_ctrl #(.RING_SECONDS(5), .SNOOZE_SECONDS(3)) dut (
        .clk            (clk),
        .reset          (reset),
        .tick_1s        (tick_1s),
        .hora_bcd       (hora_bcd),
        .min_bcd        (min_bcd),
        .seg_bcd        (seg_bcd),
        .alarm_hora_bcd (alarm_hora_bcd),
        .alarm_min_bcd  (alarm_min_bcd),
        .alarm_en       (alarm_en),
        .btn_stop       (btn_stop),
        .btn_snooze     (btn_snooze),
        .activar_alarma (activar_alarma),
        .buzzer         (buzzer),
        .estado         (estado)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_time(input int h, input int m, input int s);
        hora_bcd = 8'((h / 10) * 16 + (h % 10));
        min_bcd  = 8'((m / 10) * 16 + (m % 10));
        seg_bcd  = 8'((s / 10) * 16 + (s % 10));
    endtask

    task automatic tick();
        tick_1s = 1'b1;
        step();
        tick_1s = 1'b0;
    endtask

    // Brings the DUT from IDLE into RINGING via a 07:30:00 match.
    task automatic enter_ring();
        set_time(7, 30, 0);
        tick();
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        n_cmp++; if (activar_alarma !== 1'b0) begin n_err++; $display("FAIL reset_activar got=%b exp=0", activar_alarma); end
        n_cmp++; if (buzzer !== 1'b0) begin n_err++; $display("FAIL reset_buzzer got=%b exp=0", buzzer); end
        n_cmp++; if (estado !== 2'd0) begin n_err++; $display("FAIL reset_estado got=%0d exp=0", estado); end
        reset = 1'b1;
        step();
    endtask

    task automatic test_match_and_timeout();
        logic exp_buz;
        set_time(7, 29, 59);
        tick();
        n_cmp++; if (estado !== 2'd0) begin n_err++; $display("FAIL pre_match_estado got=%0d exp=0", estado); end
        enter_ring();
        n_cmp++; if (activar_alarma !== 1'b1) begin n_err++; $display("FAIL match_activar got=%b exp=1", activar_alarma); end
        n_cmp++; if (estado !== 2'd1) begin n_err++; $display("FAIL match_estado got=%0d exp=1", estado); end
        n_cmp++; if (buzzer !== 1'b0) begin n_err++; $display("FAIL match_buzzer got=%b exp=0", buzzer); end
        // Ticks 1..4 after entry keep ringing, buzzer toggling; a quiet cycle holds it.
        exp_buz = 1'b0;
        for (int s = 1; s <= 4; s++) begin
            set_time(7, 30, s);
            tick();
            exp_buz = ~exp_buz;
            n_cmp++; if (buzzer !== exp_buz) begin n_err++; $display("FAIL ring_buzzer_t%0d got=%b exp=%b", s, buzzer, exp_buz); end
            n_cmp++; if (activar_alarma !== 1'b1) begin n_err++; $display("FAIL ring_activar_t%0d got=%b exp=1", s, activar_alarma); end
            step();
            n_cmp++; if (buzzer !== exp_buz) begin n_err++; $display("FAIL ring_hold_t%0d got=%b exp=%b", s, buzzer, exp_buz); end
        end
        set_time(7, 30, 5);
        tick();
        n_cmp++; if (activar_alarma !== 1'b0) begin n_err++; $display("FAIL timeout_activar got=%b exp=0", activar_alarma); end
        n_cmp++; if (estado !== 2'd0) begin n_err++; $display("FAIL timeout_estado got=%0d exp=0", estado); end
        n_cmp++; if (buzzer !== 1'b0) begin n_err++; $display("FAIL timeout_buzzer got=%b exp=0", buzzer); end
        // No retrigger through the rest of the matching minute.
        for (int s = 6; s <= 59; s++) begin
            set_time(7, 30, s);
            tick();
            n_cmp++; if (estado !== 2'd0) begin n_err++; $display("FAIL no_retrigger_s%0d got=%0d exp=0", s, estado); end
        end
    endtask

    task automatic test_stop_with_tick();
        enter_ring();
        set_time(7, 30, 1);
        tick();
        n_cmp++; if (buzzer !== 1'b1) begin n_err++; $display("FAIL stop_pre_buzzer got=%b exp=1", buzzer); end
        btn_stop = 1'b1;
        step();
        n_cmp++; if (estado !== 2'd1) begin n_err++; $display("FAIL stop_latency_estado got=%0d exp=1", estado); end
        // Registered stop pulse lands together with a tick: stop must win.
        set_time(7, 30, 2);
        tick();
        n_cmp++; if (estado !== 2'd0) begin n_err++; $display("FAIL stop_tick_estado got=%0d exp=0", estado); end
        n_cmp++; if (buzzer !== 1'b0) begin n_err++; $display("FAIL stop_tick_buzzer got=%b exp=0", buzzer); end
        n_cmp++; if (activar_alarma !== 1'b0) begin n_err++; $display("FAIL stop_tick_activar got=%b exp=0", activar_alarma); end
        btn_stop = 1'b0;
        step();
    endtask

    task automatic test_disarm_ring();
        enter_ring();
        alarm_en = 1'b0;
        step();
        n_cmp++; if (estado !== 2'd0) begin n_err++; $display("FAIL disarm_ring_estado got=%0d exp=0", estado); end
        alarm_en = 1'b1;
        step();
    endtask

`ifdef ALARMA_SNOOZE_EN
    task automatic test_snooze();
        enter_ring();
        btn_snooze = 1'b1;
        step();
        step();
        n_cmp++; if (estado !== 2'd2) begin n_err++; $display("FAIL snooze_estado got=%0d exp=2", estado); end
        n_cmp++; if (activar_alarma !== 1'b0) begin n_err++; $display("FAIL snooze_activar got=%b exp=0", activar_alarma); end
        btn_snooze = 1'b0;
        for (int t = 1; t <= 2; t++) begin
            set_time(7, 30, t);
            tick();
            n_cmp++; if (estado !== 2'd2) begin n_err++; $display("FAIL snooze_wait_t%0d got=%0d exp=2", t, estado); end
        end
        set_time(7, 30, 3);
        tick();
        n_cmp++; if (estado !== 2'd1) begin n_err++; $display("FAIL snooze_rering_estado got=%0d exp=1", estado); end
        n_cmp++; if (activar_alarma !== 1'b1) begin n_err++; $display("FAIL snooze_rering_activar got=%b exp=1", activar_alarma); end
        n_cmp++; if (buzzer !== 1'b0) begin n_err++; $display("FAIL snooze_rering_buzzer got=%b exp=0", buzzer); end
        // Snooze again, then disarm while snoozing.
        btn_snooze = 1'b1;
        step();
        step();
        btn_snooze = 1'b0;
        n_cmp++; if (estado !== 2'd2) begin n_err++; $display("FAIL snooze2_estado got=%0d exp=2", estado); end
        alarm_en = 1'b0;
        step();
        n_cmp++; if (estado !== 2'd0) begin n_err++; $display("FAIL snooze_disarm_estado got=%0d exp=0", estado); end
        alarm_en = 1'b1;
        step();
    endtask
`else
    task automatic test_snooze_disabled();
        enter_ring();
        btn_snooze = 1'b1;
        step();
        step();
        n_cmp++; if (estado !== 2'd1) begin n_err++; $display("FAIL nosnooze_estado got=%0d exp=1", estado); end
        for (int t = 1; t <= 2; t++) begin
            set_time(7, 30, t);
            tick();
            n_cmp++; if (estado !== 2'd1) begin n_err++; $display("FAIL nosnooze_ring_t%0d got=%0d exp=1", t, estado); end
            n_cmp++; if (buzzer !== 1'(t % 2)) begin n_err++; $display("FAIL nosnooze_buzzer_t%0d got=%b exp=%b", t, buzzer, 1'(t % 2)); end
        end
        btn_snooze = 1'b0;
        alarm_en = 1'b0;
        step();
        n_cmp++; if (estado !== 2'd0) begin n_err++; $display("FAIL nosnooze_exit got=%0d exp=0", estado); end
        alarm_en = 1'b1;
        step();
    endtask
`endif

    task automatic test_arm_mid_minute();
        alarm_en = 1'b0;
        set_time(7, 30, 20);
        step();
        alarm_en = 1'b1;
        for (int s = 20; s <= 23; s++) begin
            set_time(7, 30, s);
            tick();
            n_cmp++; if (estado !== 2'd0) begin n_err++; $display("FAIL arm_mid_s%0d got=%0d exp=0", s, estado); end
        end
    endtask

    task automatic test_reset_mid_ring();
        enter_ring();
        set_time(7, 30, 1);
        tick();
        btn_stop = 1'b1;
        reset = 1'b0;
        #1;
        n_cmp++; if (activar_alarma !== 1'b0) begin n_err++; $display("FAIL rst_ring_activar got=%b exp=0", activar_alarma); end
        n_cmp++; if (buzzer !== 1'b0) begin n_err++; $display("FAIL rst_ring_buzzer got=%b exp=0", buzzer); end
        n_cmp++; if (estado !== 2'd0) begin n_err++; $display("FAIL rst_ring_estado got=%0d exp=0", estado); end
        step();
        reset = 1'b1;
        step();
        // Stop still held from before release: ring must not be cancelled.
        enter_ring();
        step();
        step();
        n_cmp++; if (estado !== 2'd1) begin n_err++; $display("FAIL held_stop_estado got=%0d exp=1", estado); end
        btn_stop = 1'b0;
        step();
        btn_stop = 1'b1;
        step();
        step();
        n_cmp++; if (estado !== 2'd0) begin n_err++; $display("FAIL fresh_stop_estado got=%0d exp=0", estado); end
        btn_stop = 1'b0;
        step();
    endtask

    initial begin
        reset          = 1'b0;
        tick_1s        = 1'b0;
        alarm_hora_bcd = 8'h07;
        alarm_min_bcd  = 8'h30;
        alarm_en       = 1'b1;
        btn_stop       = 1'b0;
        btn_snooze     = 1'b0;
        set_time(0, 0, 0);
        #2;
        test_reset();
        test_match_and_timeout();
        test_stop_with_tick();
        test_disarm_ring();
`ifdef ALARMA_SNOOZE_EN
        test_snooze();
`else
        test_snooze_disabled();
`endif
        test_arm_mid_minute();
        test_reset_mid_ring();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
